foo_z_window_counter: RTL

Windowed event counter that sits directly downstream of `foo` and consumes its `z` output. It counts rising edges of `z` over fixed windows of `WINDOW` clock cycles. Each window's count goes out on a valid/ready interface to the status/readback logic. `foo` itself is combinational on the `z` path, so this block is the first sequential stage on `foo`'s output.

---
 rtl/foo_z_window_counter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/foo_z_window_counter.sv
// rtl/foo_z_window_counter.sv - windowed rising-edge counter on foo z output (optional FOO_Z_GLITCH_FILTER_EN)
module foo_z_window_counter #(
    parameter int WINDOW = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             z,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow,
    output logic             out_lost
);

    localparam int               WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_z_s;
    logic             r_z_prev;
    logic             w_z_det;
    logic             w_edge;
    logic [WIN_W-1:0] r_win_cnt;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_ovf_next;
    logic             w_win_end;

    // Input sampling runs in every state so edge history survives IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_s    <= 1'b0;
            r_z_prev <= 1'b0;
        end else begin
            r_z_s    <= z;
            r_z_prev <= w_z_det;
        end
    end

`ifdef FOO_Z_GLITCH_FILTER_EN
    logic r_z_f;

    // Filtered level follows z_s only once the incoming sample matches the held one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z_f <= 1'b0;
        end else if (z == r_z_s) begin
            r_z_f <= r_z_s;
        end
    end

    assign w_z_det = r_z_f;
`else
    assign w_z_det = r_z_s;
`endif

    assign w_edge     = w_z_det & ~r_z_prev;
    assign w_win_end  = (r_state == S_COUNT) && (r_win_cnt == WIN_LAST);
    assign w_cnt_next = (w_edge && (r_edge_cnt != CNT_MAX)) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_ovf_next = r_ovf | (w_edge && (r_edge_cnt == CNT_MAX));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: counting follows enable; a window end with enable low also lands in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (enable)  w_state_next = S_COUNT;
            S_COUNT: if (!enable) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Window counters, result register and lost flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_ovf        <= 1'b0;
            out_valid    <= 1'b0;
            out_count    <= '0;
            out_overflow <= 1'b0;
            out_lost     <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (enable) begin
                    r_win_cnt  <= '0;
                    r_edge_cnt <= '0;
                    r_ovf      <= 1'b0;
                    out_lost   <= 1'b0;
                end
            end else if (w_win_end || !enable) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_ovf      <= 1'b0;
            end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_edge_cnt <= w_cnt_next;
                r_ovf      <= w_ovf_next;
            end

            if (w_win_end) begin
                if (!out_valid || out_ready) begin
                    out_valid    <= 1'b1;
                    out_count    <= w_cnt_next;
                    out_overflow <= w_ovf_next;
                end else begin
                    out_lost <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
